// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: shift-in a pattern, one capture cycle, shift-out the response.
// Optional MISR signature output enabled by defining SCAN_MISR_EN.
module scan_chain_ctrl #(
  parameter int               CHAIN_LEN = 8,
  parameter int               CNT_W     = 4,
  parameter int               SIG_W     = 16,
  parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(16'h1021)
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP_OUT
`ifdef SCAN_MISR_EN
  ,
  output logic [SIG_W-1:0]     SIG
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    FINISH    = 3'd4
  } state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CHAIN_LEN-2:0]   pat_q;
  logic [CHAIN_LEN-1:0]   resp_q;
  logic [CHAIN_LEN-1:0]   resp_out_q;
  logic                   se_q;
  logic                   si_q;
  logic                   busy_q;
  logic                   done_q;

  // Galois MISR step: shift left, fold the feedback bit through the polynomial taps.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s);
    misr_step = {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? MISR_POLY : {SIG_W{1'b0}});
  endfunction

`ifdef SCAN_MISR_EN
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_out_q;
  assign SIG = sig_out_q;
`endif

  assign SE       = se_q;
  assign SI       = si_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign RESP_OUT = resp_out_q;

  // SE/SI are set on the edge entering each state so they line up with that state's cycles;
  // DONE/RESP_OUT/BUSY-release land one cycle after FINISH.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      pat_q      <= {(CHAIN_LEN-1){1'b0}};
      resp_q     <= {CHAIN_LEN{1'b0}};
      resp_out_q <= {CHAIN_LEN{1'b0}};
      se_q       <= 1'b0;
      si_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SCAN_MISR_EN
      sig_q      <= {SIG_W{1'b0}};
      sig_out_q  <= {SIG_W{1'b0}};
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= START;
          if (START) begin
            pat_q   <= PAT_IN[CHAIN_LEN-2:0];
            cnt_q   <= {CNT_W{1'b0}};
            se_q    <= 1'b1;
            si_q    <= PAT_IN[CHAIN_LEN-1];
            state_q <= SHIFT_IN;
          end else begin
            se_q    <= 1'b0;
            si_q    <= 1'b0;
          end
        end
        SHIFT_IN: begin
          busy_q <= 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= {CNT_W{1'b0}};
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            state_q <= CAPTURE;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            si_q    <= pat_q[CHAIN_LEN-2];
            pat_q   <= pat_q << 1;
          end
        end
        CAPTURE: begin
          busy_q  <= 1'b1;
          se_q    <= 1'b1;
          si_q    <= 1'b0;
          state_q <= SHIFT_OUT;
        end
        SHIFT_OUT: begin
          busy_q <= 1'b1;
          resp_q <= {resp_q[CHAIN_LEN-2:0], SO};
`ifdef SCAN_MISR_EN
          sig_q  <= misr_step(sig_q) ^ {{(SIG_W-1){1'b0}}, SO};
`endif
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= {CNT_W{1'b0}};
            se_q    <= 1'b0;
            state_q <= FINISH;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        FINISH: begin
          busy_q     <= 1'b1;
          done_q     <= 1'b1;
          resp_out_q <= resp_q;
`ifdef SCAN_MISR_EN
          sig_out_q  <= sig_q;
`endif
          se_q       <= 1'b0;
          si_q       <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          cnt_q   <= {CNT_W{1'b0}};
          se_q    <= 1'b0;
          si_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Scoreboard bench for scan_chain_ctrl driving a 4-flop chain model with D_k = ~Q_k.
module tb_scan_chain_ctrl;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [3:0] PAT_IN = 4'b0000;
  wire        SO;
  wire        SE;
  wire        SI;
  wire        BUSY;
  wire        DONE;
  wire [3:0]  RESP_OUT;
`ifdef SCAN_MISR_EN
  wire [15:0] SIG;
`endif

  scan_chain_ctrl #(.CHAIN_LEN(4), .CNT_W(3), .SIG_W(16)) dut (
    .CK(CK), .RST(RST), .START(START), .PAT_IN(PAT_IN), .SO(SO),
    .SE(SE), .SI(SI), .BUSY(BUSY), .DONE(DONE), .RESP_OUT(RESP_OUT)
`ifdef SCAN_MISR_EN
    , .SIG(SIG)
`endif
  );

  always #5 CK = ~CK;

  // Scan flop chain: shift on SE, otherwise each flop loads its own inverse.
  logic [3:0] chain = 4'b0000;
  always @(posedge CK) chain <= SE ? {chain[2:0], SI} : ~chain;
  assign SO = chain[3];

  logic [31:0] cyc = 32'd0;
  always @(posedge CK) cyc <= cyc + 32'd1;

  typedef struct packed {
    logic [3:0]  resp;
    logic [15:0] sig;
    logic [31:0] due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each DONE against the head of the scoreboard, and flag missing DONEs.
  always @(negedge CK) begin
    if (!RST) begin
      if (DONE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_out", {28'd0, RESP_OUT}, {28'd0, mon_e.resp});
          check("done_cycle", cyc, mon_e.due);
`ifdef SCAN_MISR_EN
          check("sig", {16'd0, SIG}, {16'd0, mon_e.sig});
`endif
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
        mon_e = exp_q.pop_front();
        check("done_missing", cyc, mon_e.due);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge CK);
    while (BUSY && n < 40) begin
      @(negedge CK);
      n++;
    end
    if (BUSY) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic start_run(input logic [3:0] pat, input logic [3:0] resp,
                           input logic [15:0] sig, output logic [31:0] acc);
    wait_idle();
    PAT_IN = pat;
    START  = 1'b1;
    @(negedge CK);
    START  = 1'b0;
    PAT_IN = ~pat;
    acc    = cyc;
    exp_q.push_back('{resp: resp, sig: sig, due: acc + 32'd10});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] acc;
    logic [3:0]  p;

    // 1: reset values, held idle
    @(negedge CK);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CK);
      check("idle_se", {31'd0, SE}, 32'd0);
      check("idle_si", {31'd0, SI}, 32'd0);
      check("idle_busy", {31'd0, BUSY}, 32'd0);
      check("idle_done", {31'd0, DONE}, 32'd0);
      check("idle_resp", {28'd0, RESP_OUT}, 32'd0);
`ifdef SCAN_MISR_EN
      check("idle_sig", {16'd0, SIG}, 32'd0);
`endif
    end

    // 2: single pattern with waveform checks
    p = 4'b1010;
    start_run(p, 4'b0101, 16'h0000, acc);
    for (int i = 0; i < 4; i++) begin
      check("shin_se", {31'd0, SE}, 32'd1);
      check("shin_si", {31'd0, SI}, {31'd0, p[3-i]});
      check("shin_busy", {31'd0, BUSY}, 32'd1);
      @(negedge CK);
    end
    check("cap_se", {31'd0, SE}, 32'd0);
    check("cap_si", {31'd0, SI}, 32'd0);
    @(negedge CK);
    for (int i = 0; i < 4; i++) begin
      check("shout_se", {31'd0, SE}, 32'd1);
      check("shout_si", {31'd0, SI}, 32'd0);
      @(negedge CK);
    end
    check("finish_se", {31'd0, SE}, 32'd0);
    check("finish_busy", {31'd0, BUSY}, 32'd1);
    @(negedge CK);
    check("done_cycle_busy", {31'd0, BUSY}, 32'd1);

    // 3: back-to-back, with START pulses while busy ignored
    start_run(4'b1111, 4'b0000, 16'h0000, acc);
    for (int i = 0; i < 3; i++) begin
      @(negedge CK);
      PAT_IN = 4'b0101;
      START  = 1'b1;
      @(negedge CK);
      START  = 1'b0;
    end
    start_run(4'b0000, 4'b1111, 16'h0000, acc);

    // 4: reset during the second SHIFT_OUT cycle aborts the run
    wait_idle();
    PAT_IN = 4'b1010;
    START  = 1'b1;
    @(negedge CK);
    START  = 1'b0;
    repeat (6) @(negedge CK);
    RST = 1'b1;
    #1;
    check("abort_se", {31'd0, SE}, 32'd0);
    check("abort_si", {31'd0, SI}, 32'd0);
    check("abort_busy", {31'd0, BUSY}, 32'd0);
    check("abort_done", {31'd0, DONE}, 32'd0);
    check("abort_resp", {28'd0, RESP_OUT}, 32'd0);
    @(negedge CK);
    RST = 1'b0;
    repeat (12) @(negedge CK);
    start_run(4'b0011, 4'b1100, 16'h0000, acc);

    // 5: START held high gives one DONE every 11 cycles
    wait_idle();
    PAT_IN = 4'b0110;
    START  = 1'b1;
    @(negedge CK);
    acc = cyc;
    exp_q.push_back('{resp: 4'b1001, sig: 16'h0000, due: acc + 32'd10});
    exp_q.push_back('{resp: 4'b1001, sig: 16'h0000, due: acc + 32'd21});
    exp_q.push_back('{resp: 4'b1001, sig: 16'h0000, due: acc + 32'd32});
    repeat (32) @(negedge CK);
    START = 1'b0;

`ifdef SCAN_MISR_EN
    // 6: signature after two identical runs from reset
    wait_idle();
    RST = 1'b1;
    @(negedge CK);
    RST = 1'b0;
    start_run(4'b1010, 4'b0101, 16'h0005, acc);
    start_run(4'b1010, 4'b0101, 16'h0055, acc);
`endif

    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge CK);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    repeat (3) @(negedge CK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
